score_bcd_accumulator: RTL and testbench

- Producer side of the 4-digit BCD score bus consumed by the score_display block.
- Accepts binary point awards from game logic over a valid/ready handshake.
- Each award goes through a double-dabble binary-to-BCD conversion, then a digit-serial BCD add into the running score.
- Drives the four BCD digit buses, which update atomically. Saturates at 9999.

---
 rtl/score_bcd_accumulator_pkg.sv | 34 +++
 rtl/score_bcd_accumulator_if.sv | 23 ++
 rtl/score_bcd_accumulator_bcd_digit_adder.sv | 23 ++
 rtl/score_bcd_accumulator.sv | 119 +++++++++++
 tb/tb_score_bcd_accumulator.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/score_bcd_accumulator_pkg.sv
// Shared types and constants for the BCD score accumulator.
package score_bcd_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        ADD    = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int BCD_DIGITS    = 4;
    localparam int BCD_MAX_DIGIT = 9;
    localparam int DEF_MAX_AMT   = 999;

    // Award digits held by the conversion register (awards never exceed 999).
    localparam int CONV_W        = 12;

    // Line-clear point awards.
    localparam int PTS_1_LINE    = 40;
    localparam int PTS_2_LINES   = 100;
    localparam int PTS_3_LINES   = 300;
    localparam int PTS_4_LINES   = 999;

    // Double-dabble correction: every nibble >= 5 gets +3 ahead of the shift.
    function automatic logic [CONV_W-1:0] dd_adjust(input logic [CONV_W-1:0] v);
        logic [CONV_W-1:0] r;
        r = v;
        for (int i = 0; i < CONV_W / 4; i++) begin
            if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_bcd_accumulator_if.sv
// Award request handshake and BCD score bus.
interface score_bcd_accumulator_if #(parameter int AMT_W = 10);
    logic             clear;
    logic             add_valid;
    logic [AMT_W-1:0] add_amount;
    logic             add_ready;
    logic [3:0]       score_1;
    logic [3:0]       score_2;
    logic [3:0]       score_3;
    logic [3:0]       score_4;
    logic             done;
    logic             saturated;

    modport master (
        output clear, add_valid, add_amount,
        input  add_ready, score_1, score_2, score_3, score_4, done, saturated
    );

    modport slave (
        input  clear, add_valid, add_amount,
        output add_ready, score_1, score_2, score_3, score_4, done, saturated
    );
endinterface

// File: rtl/score_bcd_accumulator_bcd_digit_adder.sv
// Single-digit BCD adder, reused serially across the score digits.
module bcd_digit_adder
    import score_bcd_accumulator_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] raw;

    // Binary add, then fold anything above 9 back into a legal digit plus carry.
    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        sum  = raw[3:0];
        cout = 1'b0;
        if (raw > 5'(BCD_MAX_DIGIT)) begin
            sum  = 4'(raw - 5'd10);
            cout = 1'b1;
        end
    end
endmodule

// File: rtl/score_bcd_accumulator.sv
// Running 4-digit BCD score: convert each award to BCD, add it digit-serially,
// and commit all four digits at once (saturating at 9999).
module score_bcd_accumulator
    import score_bcd_accumulator_pkg::*;
#(
    parameter int AMT_W   = 10,
    parameter int MAX_AMT = DEF_MAX_AMT
) (
    input  logic                   clk,
    input  logic                   rst,
    score_bcd_accumulator_if.slave bus
);
    localparam int SR_W  = CONV_W + AMT_W;
    localparam int CNT_W = $clog2(AMT_W + 1);

    state_t                       state, next_state;
    logic [SR_W-1:0]              sr;
    logic [SR_W-1:0]              sr_adj;
    logic [CNT_W-1:0]             cnt;
    logic                         carry;
    logic [BCD_DIGITS-1:0][3:0]   score, shadow, award;
    logic                         done_q, sat_q;
    logic                         accept, conv_last, add_last;
    logic [AMT_W-1:0]             amt_clamped;
    logic [3:0]                   dsum;
    logic                         dcout;

    assign amt_clamped   = (bus.add_amount > AMT_W'(MAX_AMT)) ? AMT_W'(MAX_AMT) : bus.add_amount;
    assign bus.add_ready = (state == IDLE) && !bus.clear && !rst;
    assign accept        = bus.add_valid && bus.add_ready;
    assign conv_last     = (cnt == CNT_W'(AMT_W - 1));
    assign add_last      = (cnt == CNT_W'(BCD_DIGITS - 1));

    // Upper part of the shift register holds the award BCD once conversion is done.
    assign award  = {4'd0, sr[AMT_W +: CONV_W]};
    assign sr_adj = {dd_adjust(sr[AMT_W +: CONV_W]), sr[AMT_W-1:0]};

    assign bus.score_1   = score[0];
    assign bus.score_2   = score[1];
    assign bus.score_3   = score[2];
    assign bus.score_4   = score[3];
    assign bus.done      = done_q;
    assign bus.saturated = sat_q;

    bcd_digit_adder u_digit_add (
        .a    (score[cnt[1:0]]),
        .b    (award[cnt[1:0]]),
        .cin  (carry),
        .sum  (dsum),
        .cout (dcout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Sequencing: fixed-length CONV and ADD phases; clear aborts from anywhere.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept)    next_state = CONV;
            CONV:    if (conv_last) next_state = ADD;
            ADD:     if (add_last)  next_state = COMMIT;
            COMMIT:                 next_state = IDLE;
            default:                next_state = IDLE;
        endcase
        if (bus.clear) next_state = IDLE;
    end

    // Datapath: load, double-dabble, serial add into shadow, atomic commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            score  <= '0;
            shadow <= '0;
            sr     <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            done_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.clear) begin
                score <= '0;
                sat_q <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            sr    <= {CONV_W'(0), amt_clamped};
                            cnt   <= '0;
                            carry <= 1'b0;
                        end
                    end
                    CONV: begin
                        sr  <= sr_adj << 1;
                        cnt <= conv_last ? '0 : cnt + CNT_W'(1);
                    end
                    ADD: begin
                        shadow[cnt[1:0]] <= dsum;
                        carry            <= dcout;
                        cnt              <= cnt + CNT_W'(1);
                    end
                    COMMIT: begin
                        if (carry) begin
                            score <= {BCD_DIGITS{4'(BCD_MAX_DIGIT)}};
                            sat_q <= 1'b1;
                        end else begin
                            score <= shadow;
                        end
                        done_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_score_bcd_accumulator.sv
// Scoreboard bench: the stimulus side drives awards/clears/resets, the monitor
// predicts each committed score with plain integer arithmetic and checks it.
module tb_score_bcd_accumulator;
    import score_bcd_accumulator_pkg::*;

    localparam int AMT_W = 10;
    localparam int LAT   = AMT_W + 5;
    localparam int MAXA  = 999;

    logic clk = 1'b0;
    logic rst = 1'b1;

    score_bcd_accumulator_if #(.AMT_W(AMT_W)) bus ();

    score_bcd_accumulator #(.AMT_W(AMT_W), .MAX_AMT(MAXA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #20 clk = ~clk;

    typedef struct {
        int due;
        int score;
        bit sat;
    } exp_t;

    exp_t q[$];
    int   done_cycles[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   vis_score = 0;
    bit   vis_sat = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] dut_digits();
        return {bus.score_4, bus.score_3, bus.score_2, bus.score_1};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor + reference model; evaluated mid-cycle, then predicts the next edge.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_ready;
        int   amt, sum;
        if (cyc >= 1) begin
            if (bus.done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("done_latency", cyc, e.due);
                    vis_score = e.score;
                    vis_sat   = e.sat;
                    done_cycles.push_back(cyc);
                end
            end else if (q.size() > 0 && q[0].due == cyc) begin
                chk("missing_done", 0, 1);
                void'(q.pop_front());
            end
            chk("score", dut_digits(), to_bcd(vis_score));
            chk("saturated", bus.saturated, vis_sat);
            exp_ready = !rst && !bus.clear && (q.size() == 0);
            chk("add_ready", bus.add_ready, exp_ready);

            if (rst || bus.clear) begin
                q.delete();
                vis_score = 0;
                vis_sat   = 1'b0;
            end else if (bus.add_valid && exp_ready) begin
                amt = (int'(bus.add_amount) > MAXA) ? MAXA : int'(bus.add_amount);
                sum = vis_score + amt;
                e.due   = cyc + 1 + LAT;
                e.score = (sum > 9999) ? 9999 : sum;
                e.sat   = vis_sat || (sum > 9999);
                q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    // Present an award and hold it until the handshake completes.
    task automatic award(input int amt);
        int t;
        t = 0;
        bus.add_valid  = 1'b1;
        bus.add_amount = AMT_W'(amt);
        forever begin
            @(negedge clk);
            if (bus.add_ready) break;
            t++;
            if (t > 100) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        step();
        bus.add_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (bus.done) break;
            t++;
            if (t > 100) begin
                chk("done_timeout", 0, 1);
                break;
            end
        end
        step();
    endtask

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, op, amt, d;
        bus.clear      = 1'b0;
        bus.add_valid  = 1'b0;
        bus.add_amount = '0;
        rst            = 1'b1;
        repeat (3) step();
        chk("reset_score", dut_digits(), 16'h0000);
        chk("reset_ready", bus.add_ready, 0);
        rst = 1'b0;
        step();

        // single award
        award(PTS_1_LINE);
        wait_done();
        chk("t1_score", dut_digits(), 16'h0040);
        chk("t1_ready", bus.add_ready, 1);

        // carry chain across all digits
        do_clear();
        award(999);
        wait_done();
        chk("t2_preload", dut_digits(), 16'h0999);
        award(1);
        wait_done();
        chk("t2_carry", dut_digits(), 16'h1000);

        // clamp and saturation
        do_clear();
        for (int i = 0; i < 10; i++) begin
            award(1023);
            wait_done();
        end
        chk("t3_9990", dut_digits(), 16'h9990);
        chk("t3_not_sat", bus.saturated, 0);
        award(1023);
        wait_done();
        chk("t3_9999", dut_digits(), 16'h9999);
        chk("t3_sat", bus.saturated, 1);
        award(5);
        wait_done();
        chk("t3_hold", dut_digits(), 16'h9999);

        // clear aborts an in-flight award on CONV edge 7
        award(PTS_3_LINES);
        repeat (6) step();
        do_clear();
        chk("t4_score", dut_digits(), 16'h0000);
        chk("t4_sat", bus.saturated, 0);
        repeat (LAT + 4) step();

        // clear and valid on the same edge
        bus.clear      = 1'b1;
        bus.add_valid  = 1'b1;
        bus.add_amount = AMT_W'(PTS_2_LINES);
        @(negedge clk);
        chk("t5_ready_low", bus.add_ready, 0);
        step();
        bus.clear = 1'b0;
        chk("t5_cleared", dut_digits(), 16'h0000);
        award(PTS_2_LINES);
        wait_done();
        chk("t5_score", dut_digits(), 16'h0100);

        // back-to-back with valid held
        do_clear();
        done_cycles.delete();
        bus.add_valid  = 1'b1;
        bus.add_amount = AMT_W'(8);
        n = 0;
        for (int t = 0; t < 200 && n < 3; t++) begin
            @(negedge clk);
            if (bus.add_ready) n++;
        end
        step();
        bus.add_valid = 1'b0;
        wait_done();
        chk("t6_count", done_cycles.size(), 3);
        if (done_cycles.size() == 3) begin
            chk("t6_gap1", done_cycles[1] - done_cycles[0], AMT_W + 6);
            chk("t6_gap2", done_cycles[2] - done_cycles[1], AMT_W + 6);
        end
        chk("t6_score", dut_digits(), 16'h0024);

        // randomized awards, aborts and resets
        for (int i = 0; i < 60; i++) begin
            op  = $urandom_range(0, 11);
            amt = (op == 2) ? $urandom_range(1000, 1023) : $urandom_range(0, 999);
            if (op == 0) begin
                award(amt);
                d = $urandom_range(0, LAT + 1);
                repeat (d) step();
                do_clear();
            end else if (op == 1) begin
                award(amt);
                repeat ($urandom_range(0, LAT)) step();
                rst = 1'b1;
                step();
                step();
                rst = 1'b0;
            end else begin
                award(amt);
                wait_done();
            end
            repeat ($urandom_range(0, 3)) step();
        end

        repeat (LAT + 5) step();
        chk("pending_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
